pc_fetch_sequencer: RTL and testbench

Fetch-stage controller that owns and sequences the 32-bit program counter of the pipelined core. It issues fetch addresses to instruction memory under a valid/ready handshake, advances sequentially by 4, and applies branch and exception redirects with fixed priority. A redirect that arrives while a request is outstanding is held until that request completes. It drives the one-cycle pipeline flush pulse that kills wrong-path instructions in IF/ID and ID/EX.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_fetch_sequencer_if.sv | 10 +
 rtl/pc_next_sel.sv | 34 +++
 rtl/pc_fetch_sequencer.sv | 116 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10
  } seq_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0200;
  localparam logic [31:0] PC_INC               = 32'd4;

  // Instruction fetches are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch request bus between the PC sequencer (master) and instruction memory (slave).
interface pc_fetch_sequencer_if;
  logic        fetch_valid;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  modport master (output fetch_valid, output pc, output pc_plus4, input imem_ready);
  modport slave  (input fetch_valid, input pc, input pc_plus4, output imem_ready);
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: exception > branch > pending target > pc+4.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        exc_req_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        pend_valid_i,
  input  logic [31:0] pend_target_i,
  input  logic [31:0] pc_plus4_i,
  output logic        redirect_o,
  output logic [31:0] redirect_target_o,
  output logic [31:0] next_pc_o
);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    redirect_o        = exc_req_i | br_taken_i;
    redirect_target_o = align_word(br_target_i);
    if (exc_req_i) begin
      redirect_target_o = EXC_VECTOR;
    end

    next_pc_o = pc_plus4_i;
    if (redirect_o) begin
      next_pc_o = redirect_target_o;
    end else if (pend_valid_i) begin
      next_pc_o = pend_target_i;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC sequencer: issues fetch requests, applies redirects, drives the flush pulse.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pc_fetch_sequencer_if.master        imem,
  input  logic                        stall_i,
  input  logic                        br_taken_i,
  input  logic [31:0]                 br_target_i,
  input  logic                        exc_req_i,
  output logic                        flush_o,
  output logic [1:0]                  seq_state_o
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        flush_q, flush_d;

  logic        fetch_valid;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + PC_INC;

  // A request stays presented through WAIT even if the hazard unit stalls.
  assign fetch_valid = ((state_q == RUN) && !stall_i) || (state_q == WAIT);

  pc_next_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_sel (
    .exc_req_i        (exc_req_i),
    .br_taken_i       (br_taken_i),
    .br_target_i      (br_target_i),
    .pend_valid_i     (pend_valid_q),
    .pend_target_i    (pend_target_q),
    .pc_plus4_i       (pc_plus4),
    .redirect_o       (redirect),
    .redirect_target_o(redirect_target),
    .next_pc_o        (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    flush_d       = redirect;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect) begin
          pc_d = redirect_target;
        end
      end
      RUN: begin
        if (fetch_valid && imem.imem_ready) begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
        end else if (fetch_valid) begin
          // Request now outstanding: a same-cycle redirect must wait for it.
          state_d = WAIT;
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
        end else if (redirect) begin
          pc_d = redirect_target;
        end
      end
      WAIT: begin
        if (imem.imem_ready) begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
          state_d      = RUN;
        end else if (redirect) begin
          pend_valid_d  = 1'b1;
          pend_target_d = redirect_target;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      flush_q       <= flush_d;
    end
  end

  assign imem.fetch_valid = fetch_valid;
  assign imem.pc          = pc_q;
  assign imem.pc_plus4    = pc_plus4;
  assign flush_o          = flush_q;
  assign seq_state_o      = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a randomized run
// against a transaction-level model of the fetch PC.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        flush;
  logic [1:0]  seq_state;

  int errors = 0;
  int checks = 0;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .stall_i    (stall),
    .br_taken_i (br_taken),
    .br_target_i(br_target),
    .exc_req_i  (exc_req),
    .flush_o    (flush),
    .seq_state_o(seq_state)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic e,
                       input logic r);
    stall          = s;
    br_taken       = b;
    br_target      = t;
    exc_req        = e;
    bus.imem_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.pc !== RST_VEC) begin errors++; $display("FAIL rst_pc: got %h want %h", bus.pc, RST_VEC); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.fetch_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
    rst_n = 1'b1;
    #1;
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL boot_state: got %0d want 0", seq_state); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", bus.fetch_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", k, bus.pc, 32'(4 * k)); end
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", k, bus.fetch_valid); end
    end
  endtask

  task automatic test_backpressure();
    tick();  // pc 0xC accepted -> 0x10
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL bp_start: got %h want 10", bus.pc); end
    for (int i = 0; i < 4; i++) begin
      drive(i == 2, 0, 32'h0, 0, 0);
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", i, bus.fetch_valid); end
      tick();
      checks++; if (seq_state !== 2'b10) begin errors++; $display("FAIL bp_state%0d: got %0d want 2", i, seq_state); end
      checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL bp_pc%0d: got %h want 10", i, bus.pc); end
    end
    drive(0, 0, 32'h0, 0, 1);
    tick();
    checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL bp_release: got %h want 14", bus.pc); end
    checks++; if (seq_state !== 2'b01) begin errors++; $display("FAIL bp_run: got %0d want 1", seq_state); end
  endtask

  task automatic test_redirect_wait();
    for (int i = 0; i < 3; i++) tick();
    drive(0, 0, 32'h0, 0, 0);
    tick();
    checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL rw_wait_pc: got %h want 20", bus.pc); end
    drive(0, 1, 32'h103, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rw_flush: got %b want 1", flush); end
    checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL rw_hold: got %h want 20", bus.pc); end
    drive(0, 0, 32'h0, 0, 1);
    tick();
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL rw_target: got %h want 100", bus.pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rw_flush_end: got %b want 0", flush); end
    tick();
    checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL rw_next: got %h want 104", bus.pc); end
  endtask

  task automatic test_priority();
    drive(0, 1, 32'h400, 1, 1);
    tick();
    drive(0, 0, 32'h0, 0, 1);
    checks++; if (bus.pc !== EXC_VEC) begin errors++; $display("FAIL pri_pc: got %h want %h", bus.pc, EXC_VEC); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pri_flush: got %b want 1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL pri_single: got %b want 0", flush); end
    checks++; if (bus.pc !== 32'h204) begin errors++; $display("FAIL pri_next: got %h want 204", bus.pc); end
  endtask

  task automatic test_stall_wrap();
    drive(1, 0, 32'h0, 0, 1);
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL st_valid: got %b want 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.pc !== 32'h204) begin errors++; $display("FAIL st_hold: got %h want 204", bus.pc); end
    drive(1, 1, 32'hFFFF_FFFF, 0, 1);
    tick();
    drive(1, 0, 32'h0, 0, 1);
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL st_redirect: got %h want fffffffc", bus.pc); end
    checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 0", bus.pc_plus4); end
    drive(0, 0, 32'h0, 0, 1);
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL st_unstall: got %b want 1", bus.fetch_valid); end
    tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", bus.pc); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 32'h40, 0, 1);
    tick();
    checks++; if (bus.pc !== 32'h40 || flush !== 1'b1) begin errors++; $display("FAIL b2b_first: pc %h flush %b want 40/1", bus.pc, flush); end
    drive(0, 1, 32'h80, 0, 1);
    tick();
    checks++; if (bus.pc !== 32'h80 || flush !== 1'b1) begin errors++; $display("FAIL b2b_second: pc %h flush %b want 80/1", bus.pc, flush); end
    drive(0, 0, 32'h0, 0, 1);
    tick();
    checks++; if (bus.pc !== 32'h84 || flush !== 1'b0) begin errors++; $display("FAIL b2b_after: pc %h flush %b want 84/0", bus.pc, flush); end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 32'h0, 0, 0);
    tick();
    drive(0, 1, 32'h300, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0);
    checks++; if (seq_state !== 2'b10 || flush !== 1'b1) begin errors++; $display("FAIL ar_pre: state %0d flush %b want 2/1", seq_state, flush); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== RST_VEC) begin errors++; $display("FAIL ar_pc: got %h want %h", bus.pc, RST_VEC); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.fetch_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ar_flush: got %b want 0", flush); end
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL ar_pend_cleared: got %h want 4", bus.pc); end
  endtask

  // Model tracks the fetch stream as transactions: a boot gap, an outstanding
  // request flag, and at most one deferred redirect target.
  task automatic test_random();
    bit          m_boot, m_out, m_flush, red, exp_v, s, r, b, e;
    logic [31:0] m_pc, t, tgt;
    logic [31:0] m_pend[$];
    logic [1:0]  exp_state;

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 1);
    tick();
    rst_n   = 1'b1;
    m_boot  = 1'b1;
    m_out   = 1'b0;
    m_flush = 1'b0;
    m_pc    = RST_VEC;
    m_pend.delete();

    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(3) == 0);
      r = ($urandom_range(9) < 7);
      b = (i > 0) && ($urandom_range(6) == 0);
      e = (i > 0) && ($urandom_range(11) == 0);
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      drive(s, b, t, e, r);

      exp_v = !m_boot && (m_out || !s);
      checks++; if (bus.fetch_valid !== exp_v) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.fetch_valid, exp_v); end

      red = b || e;
      tgt = e ? EXC_VEC : {t[31:2], 2'b00};
      if (m_boot) begin
        m_boot = 1'b0;
        if (red) m_pc = tgt;
      end else if (exp_v && r) begin
        m_pc  = red ? tgt : (m_pend.size() != 0 ? m_pend[0] : m_pc + 32'd4);
        m_out = 1'b0;
        m_pend.delete();
      end else if (exp_v) begin
        m_out = 1'b1;
        if (red) begin
          m_pend.delete();
          m_pend.push_back(tgt);
        end
      end else if (red) begin
        m_pc = tgt;
      end
      m_flush = red;
      tick();

      exp_state = m_boot ? 2'b00 : (m_out ? 2'b10 : 2'b01);
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", i, bus.pc, m_pc); end
      checks++; if (bus.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4@%0d: got %h want %h", i, bus.pc_plus4, m_pc + 32'd4); end
      checks++; if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush@%0d: got %b want %b", i, flush, m_flush); end
      checks++; if (seq_state !== exp_state) begin errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", i, seq_state, exp_state); end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_wait();
    test_priority();
    test_stall_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
